// File: rtl/rom_dl_packer_if.sv
// rtl/rom_dl_packer_if.sv - toggle req/ack RAM write port between the download packer and the RAM controller
interface rom_dl_packer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 22
);
  logic                  ram_req;
  logic                  ram_ack;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_W-1:0]     ram_din;
  logic [DATA_W/8-1:0]   ram_ds;
  logic                  ram_we;

  modport master (
    output ram_req,
    output ram_addr,
    output ram_din,
    output ram_ds,
    output ram_we,
    input  ram_ack
  );

  modport slave (
    input  ram_req,
    input  ram_addr,
    input  ram_din,
    input  ram_ds,
    input  ram_we,
    output ram_ack
  );
endinterface

// File: rtl/rom_dl_packer.sv
// rtl/rom_dl_packer.sv - packs ioctl download bytes into RAM words and issues them over a toggle req/ack port
module rom_dl_packer #(
  parameter int         DATA_W     = 16,
  parameter int         ADDR_W     = 22,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] INDEX_VAL  = 8'h00,
  parameter logic [7:0] INDEX_MASK = 8'hFF
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  ioctl_download,
  input  logic [7:0]            ioctl_index,
  input  logic                  ioctl_wr,
  input  logic [24:0]           ioctl_addr,
  input  logic [7:0]            ioctl_dout,
  rom_dl_packer_if.master       ram,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [23:0]           words_written
);

  localparam int B     = DATA_W / 8;
  localparam int SHIFT = $clog2(B);
  localparam int LB    = (B > 1) ? SHIFT : 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int EW    = ADDR_W + DATA_W + B;

  logic              dl_q, wr_q;
  logic              dl_rise, dl_fall, index_ok, accept;
  logic [LB-1:0]     lane;
  logic              last_lane;
  logic [24:0]       addr_sh;
  logic [ADDR_W-1:0] waddr;
  logic [B-1:0]      lane_bit;
  logic [DATA_W-1:0] new_data, merged_data, byte_data;
  logic              unused_addr;

  logic [ADDR_W-1:0] pk_addr;
  logic [DATA_W-1:0] pk_data;
  logic [B-1:0]      pk_ds;
  logic              pk_flush_next, pk_busy;

  logic              fl_valid;
  logic [ADDR_W-1:0] fl_addr;
  logic [DATA_W-1:0] fl_data;
  logic [B-1:0]      fl_ds;

  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [EW-1:0]     head;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic              fifo_empty, fifo_full, outstanding, issue, push, drop;
  logic              req_pending, seen, busy_next;

  assign dl_rise     = ioctl_download & ~dl_q;
  assign dl_fall     = ~ioctl_download & dl_q;
  assign index_ok    = (ioctl_index & INDEX_MASK) == (INDEX_VAL & INDEX_MASK);
  assign accept      = ioctl_wr & ~wr_q & ioctl_download & index_ok;
  assign lane        = LB'(ioctl_addr) & LB'(B - 1);
  assign last_lane   = (lane == LB'(B - 1));
  assign addr_sh     = ioctl_addr >> SHIFT;
  assign waddr       = ADDR_W'(addr_sh);
  assign unused_addr = ^addr_sh;
  assign pk_busy     = |pk_ds;
  // an empty packer starts from a clean word so stale lanes never leak out
  assign byte_data   = pk_busy ? merged_data : new_data;

  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == (PW+1)'(FIFO_DEPTH));
  assign outstanding = (ram.ram_req != ram.ram_ack);
  assign issue       = ~fifo_empty & ~outstanding;
  assign push        = fl_valid & (~fifo_full | issue);
  assign drop        = fl_valid & fifo_full & ~issue;
  assign head        = mem[rd_ptr];
  assign busy_next   = ioctl_download | pk_busy | fl_valid | ~fifo_empty | outstanding;

  // place the incoming byte into its lane, both fresh and merged into the packer word
  always_comb begin
    lane_bit    = '0;
    new_data    = '0;
    merged_data = pk_data;
    for (int i = 0; i < B; i++) begin
      if (LB'(i) == lane) begin
        lane_bit[i]            = 1'b1;
        new_data[i*8 +: 8]     = ioctl_dout;
        merged_data[i*8 +: 8]  = ioctl_dout;
      end
    end
  end

  // edge detectors for the download window and the byte strobe
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      wr_q <= ioctl_wr;
    end
  end

  // packer word plus flush staging register; staged entries reach the FIFO one cycle later
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pk_addr       <= '0;
      pk_data       <= '0;
      pk_ds         <= '0;
      pk_flush_next <= 1'b0;
      fl_valid      <= 1'b0;
      fl_addr       <= '0;
      fl_data       <= '0;
      fl_ds         <= '0;
    end else begin
      fl_valid <= 1'b0;
      if (accept && pk_busy && (waddr != pk_addr)) begin
        fl_valid      <= 1'b1;
        fl_addr       <= pk_addr;
        fl_data       <= pk_data;
        fl_ds         <= pk_ds;
        pk_addr       <= waddr;
        pk_data       <= new_data;
        pk_ds         <= lane_bit;
        // staging slot is taken by the old word, so a last-lane byte here flushes a cycle later
        pk_flush_next <= last_lane;
      end else if (accept && last_lane) begin
        fl_valid      <= 1'b1;
        fl_addr       <= waddr;
        fl_data       <= byte_data;
        fl_ds         <= pk_ds | lane_bit;
        pk_ds         <= '0;
        pk_flush_next <= 1'b0;
      end else if (accept) begin
        pk_addr       <= waddr;
        pk_data       <= byte_data;
        pk_ds         <= pk_ds | lane_bit;
      end else if (pk_busy && (pk_flush_next || dl_fall)) begin
        fl_valid      <= 1'b1;
        fl_addr       <= pk_addr;
        fl_data       <= pk_data;
        fl_ds         <= pk_ds;
        pk_ds         <= '0;
        pk_flush_next <= 1'b0;
      end
    end
  end

  // FIFO storage; contents need no reset since the pointers qualify them
  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= {fl_addr, fl_data, fl_ds};
  end

  // FIFO pointers and occupancy; a push into a full FIFO lands when the head pops the same cycle
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      case ({push, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // issue the head word and toggle the request; outputs hold while the request is outstanding
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ram.ram_req  <= 1'b0;
      ram.ram_addr <= '0;
      ram.ram_din  <= '0;
      ram.ram_ds   <= '0;
    end else if (issue) begin
      ram.ram_req  <= ~ram.ram_req;
      ram.ram_addr <= head[EW-1 -: ADDR_W];
      ram.ram_din  <= head[B +: DATA_W];
      ram.ram_ds   <= head[B-1:0];
    end
  end

  // acknowledge counting, overflow, busy/we and the completion pulse
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      req_pending   <= 1'b0;
      words_written <= '0;
      overflow      <= 1'b0;
      seen          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      ram.ram_we    <= 1'b0;
    end else begin
      // a stale ack left over from before reset is not one of ours and is never counted
      if (issue)             req_pending <= 1'b1;
      else if (!outstanding) req_pending <= 1'b0;

      if (dl_rise) begin
        overflow      <= 1'b0;
        words_written <= '0;
      end else begin
        if (drop)                        overflow      <= 1'b1;
        if (req_pending && !outstanding) words_written <= words_written + 24'd1;
      end

      if (dl_rise)     seen <= accept;
      else if (accept) seen <= 1'b1;
      else if (done)   seen <= 1'b0;

      busy       <= busy_next;
      ram.ram_we <= busy_next;
      done       <= busy & ~busy_next & seen;
    end
  end

endmodule

// File: tb/tb_rom_dl_packer.sv
// tb/tb_rom_dl_packer.sv - directed bench for rom_dl_packer (16-bit/depth-2 and 32-bit/index-1 instances)
module tb_rom_dl_packer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        dl, wr;
  logic [7:0]  idx, dout;
  logic [24:0] addr;

  logic        a_busy, a_done, a_ovf, b_busy, b_done, b_ovf;
  logic [23:0] a_ww, b_ww;

  logic        hold_a;
  logic [1:0]  force_a;

  int tests = 0;
  int fails = 0;

  logic [21:0] qa_addr[$], qb_addr[$];
  logic [31:0] qa_din[$],  qb_din[$];
  logic [3:0]  qa_ds[$],   qb_ds[$];
  int          a_dones, b_dones;

  rom_dl_packer_if #(.DATA_W(16), .ADDR_W(22)) ia ();
  rom_dl_packer_if #(.DATA_W(32), .ADDR_W(22)) ib ();

  rom_dl_packer #(.DATA_W(16), .ADDR_W(22), .FIFO_DEPTH(2), .INDEX_VAL(8'h00), .INDEX_MASK(8'hFF)) dut_a (
    .clk_sys(clk), .reset_n(rst_n), .ioctl_download(dl), .ioctl_index(idx), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .ram(ia), .busy(a_busy), .done(a_done),
    .overflow(a_ovf), .words_written(a_ww));

  rom_dl_packer #(.DATA_W(32), .ADDR_W(22), .FIFO_DEPTH(4), .INDEX_VAL(8'h01), .INDEX_MASK(8'hFF)) dut_b (
    .clk_sys(clk), .reset_n(rst_n), .ioctl_download(dl), .ioctl_index(idx), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .ram(ib), .busy(b_busy), .done(b_done),
    .overflow(b_ovf), .words_written(b_ww));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_dl(input logic [7:0] i);
    tick(1);
    dl  = 1'b1;
    idx = i;
  endtask

  task automatic end_dl();
    tick(1);
    dl = 1'b0;
  endtask

  task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
    tick(1);
    addr = a;
    dout = d;
    wr   = 1'b1;
    tick(1);
    wr   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((a_busy || b_busy) && n < 300) begin
      tick(1);
      n++;
    end
    check(tag, n < 300, 1'b1);
    tick(3);
  endtask

  // RAM controller model for instance A: ack two cycles after a request, with hold and override
  initial begin
    int cnt;
    cnt = 0;
    ia.ram_ack = 1'b0;
    forever begin
      tick(1);
      if (force_a[1]) begin
        ia.ram_ack = force_a[0];
        cnt = 0;
      end else if (!hold_a && ia.ram_req != ia.ram_ack) begin
        cnt++;
        if (cnt == 2) begin
          ia.ram_ack = ia.ram_req;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // RAM controller model for instance B: ack two cycles after a request
  initial begin
    int cnt;
    cnt = 0;
    ib.ram_ack = 1'b0;
    forever begin
      tick(1);
      if (ib.ram_req != ib.ram_ack) begin
        cnt++;
        if (cnt == 2) begin
          ib.ram_ack = ib.ram_req;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // request and done monitors
  initial begin
    logic la, lb;
    la = 1'b0;
    lb = 1'b0;
    a_dones = 0;
    b_dones = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        la = ia.ram_req;
        lb = ib.ram_req;
      end else begin
        if (ia.ram_req != la) begin
          qa_addr.push_back(ia.ram_addr);
          qa_din.push_back(32'(ia.ram_din));
          qa_ds.push_back(4'(ia.ram_ds));
          la = ia.ram_req;
        end
        if (ib.ram_req != lb) begin
          qb_addr.push_back(ib.ram_addr);
          qb_din.push_back(ib.ram_din);
          qb_ds.push_back(ib.ram_ds);
          lb = ib.ram_req;
        end
        if (a_done) a_dones++;
        if (b_done) b_dones++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int na, nb, da, db;
    logic [31:0] w;
    rst_n   = 1'b0;
    dl      = 1'b0;
    wr      = 1'b0;
    idx     = 8'h00;
    addr    = '0;
    dout    = 8'h00;
    hold_a  = 1'b0;
    force_a = 2'b00;
    tick(3);
    check("reset a ram_req", ia.ram_req, 1'b0);
    check("reset a ram_we", ia.ram_we, 1'b0);
    check("reset a busy", a_busy, 1'b0);
    check("reset a done", a_done, 1'b0);
    check("reset a overflow", a_ovf, 1'b0);
    check("reset a words", a_ww, 24'd0);
    check("reset b ram_ds", ib.ram_ds, 4'h0);
    rst_n = 1'b1;
    tick(2);

    // full 16-bit words on A; B filters index 0
    na = qa_addr.size(); nb = qb_addr.size(); da = a_dones; db = b_dones;
    start_dl(8'h00);
    tick(1);
    check("t5 b busy during dl", b_busy, 1'b1);
    write_byte(25'd0, 8'hAA);
    write_byte(25'd1, 8'hBB);
    tick(1);
    check("t1 req at n+1", ia.ram_req, 1'b0);
    tick(1);
    check("t1 req at n+2", ia.ram_req, 1'b1);
    write_byte(25'd2, 8'hCC);
    write_byte(25'd3, 8'hDD);
    end_dl();
    wait_idle("t1 idle");
    check("t1 req count", qa_addr.size() - na, 2);
    check("t1 req0 addr", qa_addr[na], 22'd0);
    check("t1 req0 din", qa_din[na], 32'h0000BBAA);
    check("t1 req0 ds", qa_ds[na], 4'b0011);
    check("t1 req1 addr", qa_addr[na+1], 22'd1);
    check("t1 req1 din", qa_din[na+1], 32'h0000DDCC);
    check("t1 req1 ds", qa_ds[na+1], 4'b0011);
    check("t1 words", a_ww, 24'd2);
    check("t1 done count", a_dones - da, 1);
    check("t1 overflow", a_ovf, 1'b0);
    check("t5 b no requests", qb_addr.size() - nb, 0);
    check("t5 b no done", b_dones - db, 0);
    check("t5 b busy fell", b_busy, 1'b0);

    // partial last word flushed at download end
    na = qa_addr.size(); da = a_dones;
    start_dl(8'h00);
    write_byte(25'd0, 8'h11);
    write_byte(25'd1, 8'h22);
    write_byte(25'd2, 8'h33);
    end_dl();
    wait_idle("t2 idle");
    check("t2 req count", qa_addr.size() - na, 2);
    check("t2 tail addr", qa_addr[na+1], 22'd1);
    w = qa_din[na+1];
    check("t2 tail din lo", w[7:0], 8'h33);
    check("t2 tail ds", qa_ds[na+1], 4'b0001);
    check("t2 words", a_ww, 24'd2);
    check("t2 done count", a_dones - da, 1);

    // 32-bit on B with an address jump; A filters index 1
    na = qa_addr.size(); nb = qb_addr.size(); da = a_dones; db = b_dones;
    start_dl(8'h01);
    write_byte(25'd0, 8'h10);
    write_byte(25'd1, 8'h20);
    write_byte(25'd9, 8'h30);
    end_dl();
    wait_idle("t3 idle");
    check("t3 req count", qb_addr.size() - nb, 2);
    check("t3 req0 addr", qb_addr[nb], 22'd0);
    w = qb_din[nb];
    check("t3 req0 din", w[15:0], 16'h2010);
    check("t3 req0 ds", qb_ds[nb], 4'b0011);
    check("t3 req1 addr", qb_addr[nb+1], 22'd2);
    w = qb_din[nb+1];
    check("t3 req1 din", w[15:8], 8'h30);
    check("t3 req1 ds", qb_ds[nb+1], 4'b0010);
    check("t3 words", b_ww, 24'd2);
    check("t3 done count", b_dones - db, 1);
    check("t3 a filtered", qa_addr.size() - na, 0);
    check("t3 a no done", a_dones - da, 0);

    // FIFO overflow on A with ack held
    na = qa_addr.size(); da = a_dones;
    hold_a = 1'b1;
    start_dl(8'h00);
    for (int i = 0; i < 16; i++) write_byte(25'(i), 8'(8'h40 + i));
    tick(4);
    check("t4 one outstanding", qa_addr.size() - na, 1);
    check("t4 overflow set", a_ovf, 1'b1);
    end_dl();
    tick(1);
    hold_a = 1'b0;
    wait_idle("t4 idle");
    check("t4 req count", qa_addr.size() - na, 3);
    check("t4 req2 addr", qa_addr[na+2], 22'd2);
    check("t4 req2 din", qa_din[na+2], 32'h00004544);
    check("t4 words", a_ww, 24'd3);
    check("t4 overflow sticky", a_ovf, 1'b1);
    check("t4 done count", a_dones - da, 1);
    da = a_dones;
    start_dl(8'h00);
    tick(1);
    check("t4 overflow cleared", a_ovf, 1'b0);
    check("t4 words cleared", a_ww, 24'd0);
    end_dl();
    wait_idle("t4 empty idle");
    check("t4 empty no done", a_dones - da, 0);

    // reset with a request outstanding, then a stale ack after release
    start_dl(8'h00);
    write_byte(25'd0, 8'h61);
    write_byte(25'd1, 8'h62);
    tick(6);
    hold_a = 1'b1;
    write_byte(25'd4, 8'h71);
    write_byte(25'd5, 8'h72);
    tick(3);
    check("t6 pre outstanding", ia.ram_req != ia.ram_ack, 1'b1);
    check("t6 pre words", a_ww, 24'd1);
    #2;
    rst_n = 1'b0;
    dl    = 1'b0;
    #1;
    check("t6 rst ram_req", ia.ram_req, 1'b0);
    check("t6 rst ram_addr", ia.ram_addr, 22'd0);
    check("t6 rst ram_din", ia.ram_din, 16'h0000);
    check("t6 rst ram_ds", ia.ram_ds, 2'b00);
    check("t6 rst ram_we", ia.ram_we, 1'b0);
    check("t6 rst busy", a_busy, 1'b0);
    check("t6 rst words", a_ww, 24'd0);
    check("t6 rst overflow", a_ovf, 1'b0);
    force_a = 2'b11;
    tick(2);
    rst_n = 1'b1;
    na = qa_addr.size(); da = a_dones;
    start_dl(8'h00);
    write_byte(25'd0, 8'h5A);
    write_byte(25'd1, 8'hA5);
    tick(6);
    check("t6 held by stale ack", ia.ram_req, 1'b0);
    check("t6 busy while stale", a_busy, 1'b1);
    force_a = 2'b10;
    tick(2);
    force_a = 2'b00;
    hold_a  = 1'b0;
    end_dl();
    wait_idle("t6 idle");
    check("t6 req count", qa_addr.size() - na, 1);
    check("t6 req addr", qa_addr[na], 22'd0);
    check("t6 req din", qa_din[na], 32'h0000A55A);
    check("t6 req ds", qa_ds[na], 4'b0011);
    check("t6 words", a_ww, 24'd1);
    check("t6 done count", a_dones - da, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
